// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Load/store unit between the CPU datapath and the memory slave on
//            the system bus. Accepts one request at a time, drives a single
//            bus access per request, replicates store data across byte lanes
//            and extracts/extends load data. Bus faults (and the illegal size
//            encoding) come back as a response error and never strobe memory.
// Ports    : clk, rst (async, active-high)
//            req_*  : request handshake from CPU (valid/ready, we, size,
//                     unsigned, addr, wdata)
//            resp_* : response handshake to CPU (valid/ready, rdata, error)
//            bus_*  : single-cycle bus access (addr, size, rd, wr, wdata,
//                     rdata one cycle after rd, combinational error)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [1:0]            bus_size,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic [BUS_WIDTH-1:0]  bus_wdata,
  input  logic [BUS_WIDTH-1:0]  bus_rdata,
  input  logic                  bus_error
);

  localparam logic [1:0] C_SIZE_BYTE = 2'b00;
  localparam logic [1:0] C_SIZE_HALF = 2'b01;
  localparam logic [1:0] C_SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic                  w_fault;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_ext;
  logic [BUS_WIDTH-1:0]  w_wdata_rep;

  // The memory selects lanes of unshifted wdata with byte enables, so the
  // narrow store value must appear in every lane it could land in.
  always_comb begin
    case (req_size)
      C_SIZE_BYTE: w_wdata_rep = {4{req_wdata[7:0]}};
      C_SIZE_HALF: w_wdata_rep = {2{req_wdata[15:0]}};
      default:     w_wdata_rep = req_wdata;
    endcase
  end

  // bus_error depends only on addr/size, so gating rd/wr with it is loop-free.
  assign w_fault = bus_error || (size_q == C_SIZE_ILL);

  // Lane extraction from the returned word.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      C_SIZE_BYTE: w_load_ext = uns_q ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      C_SIZE_HALF: w_load_ext = uns_q ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default:     w_load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    we_d      = we_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    req_ready = 1'b0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = w_wdata_rep;
          rdata_d = 32'd0;
          error_d = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus_rd = !we_q && !w_fault;
        bus_wr = we_q && !w_fault;
        if (w_fault) begin
          error_d = 1'b1;
          state_d = ST_RESP;
        end else if (we_q) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        rdata_d = w_load_ext;
        state_d = ST_RESP;
      end
      default: begin
        // No bypass: a new request is only taken once IDLE is reached.
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;
  assign bus_addr   = addr_q;
  assign bus_size   = size_q;
  assign bus_wdata  = wdata_q;

endmodule
`default_nettype wire
